// File: rtl/rn_w_sequencer.sv
// RN write-path sequencer: queues accepted AW entries in order, gates CPU W beats
// onto the NoC with head/tail/target markers, and caps the number of writes in flight.
module rn_w_sequencer #(
   parameter int DEPTH     = 4,
   parameter int MAX_OUTST = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [10:0] s_awid,
   input  logic [7:0]  s_awlen,
   input  logic [1:0]  s_aw_tgtid,
   output logic        m_aw_valid,
   input  logic        m_aw_ready,
   input  logic        s_wvalid,
   output logic        s_wready,
   input  logic        s_wlast,
   output logic        m_w_valid,
   input  logic        m_w_ready,
   output logic        m_w_head,
   output logic        m_w_tail,
   output logic [1:0]  m_w_tgtid,
   output logic [9:0]  m_w_id,
   input  logic        b_fire,
   output logic [7:0]  outst_cnt,
   output logic        err_wlast,
   output logic        err_b_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   // Entry layout: {id[9:0], len[7:0], tgt[1:0]}
   logic [19:0] mem [DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [7:0]  beat_cnt;
   logic [19:0] head_entry;
   logic [7:0]  head_len;
   logic        full;
   logic        empty;
   logic        aw_ok;
   logic        w_ok;
   logic        aw_hs;
   logic        w_hs;
   logic        unused_awid_msb;

   assign unused_awid_msb = s_awid[10];

   // Extra pointer bit distinguishes full from empty when the indices coincide.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   assign aw_ok      = !full && (outst_cnt < MAX_CNT) && !rst;
   assign m_aw_valid = s_awvalid && aw_ok;
   assign s_awready  = m_aw_ready && aw_ok;
   assign aw_hs      = s_awvalid && s_awready;

   assign w_ok      = !empty && !rst;
   assign m_w_valid = s_wvalid && w_ok;
   assign s_wready  = m_w_ready && w_ok;
   assign w_hs      = s_wvalid && s_wready;

   // An empty queue presents an all-zero entry, so head and tail both read 1.
   assign head_entry = empty ? 20'd0 : mem[rd_ptr[PW-1:0]];
   assign head_len   = head_entry[9:2];
   assign m_w_id     = head_entry[19:10];
   assign m_w_tgtid  = head_entry[1:0];
   assign m_w_head   = (beat_cnt == 8'd0);
   assign m_w_tail   = (beat_cnt == head_len);

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         mem[wr_ptr[PW-1:0]] <= {s_awid[9:0], s_awlen, s_aw_tgtid};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         if (aw_hs) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (w_hs) begin
            if (m_w_tail) begin
               rd_ptr   <= rd_ptr + PTR_ONE;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + 8'd1;
            end
         end
      end
   end

   // A B response with nothing in flight is flagged but never drives the count below 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         outst_cnt       <= '0;
         err_wlast       <= 1'b0;
         err_b_underflow <= 1'b0;
      end else begin
         if (aw_hs && !b_fire) begin
            outst_cnt <= outst_cnt + 8'd1;
         end else if (!aw_hs && b_fire && (outst_cnt != 8'd0)) begin
            outst_cnt <= outst_cnt - 8'd1;
         end
         err_wlast       <= w_hs && (s_wlast != m_w_tail);
         err_b_underflow <= b_fire && (outst_cnt == 8'd0);
      end
   end

endmodule

// File: tb/tb_rn_w_sequencer.sv
// Bench for rn_w_sequencer: a queue-based reference model predicts handshakes and
// counters; a scoreboard of expected W beats is checked by a separate monitor.
module tb_rn_w_sequencer;

   localparam int DEPTH     = 4;
   localparam int MAX_OUTST = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [10:0] s_awid = '0;
   logic [7:0]  s_awlen = '0;
   logic [1:0]  s_aw_tgtid = '0;
   logic        m_aw_valid;
   logic        m_aw_ready = 1'b0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic        s_wlast = 1'b0;
   logic        m_w_valid;
   logic        m_w_ready = 1'b0;
   logic        m_w_head;
   logic        m_w_tail;
   logic [1:0]  m_w_tgtid;
   logic [9:0]  m_w_id;
   logic        b_fire = 1'b0;
   logic [7:0]  outst_cnt;
   logic        err_wlast;
   logic        err_b_underflow;

   rn_w_sequencer #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
      .s_awlen(s_awlen), .s_aw_tgtid(s_aw_tgtid),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_w_head(m_w_head), .m_w_tail(m_w_tail),
      .m_w_tgtid(m_w_tgtid), .m_w_id(m_w_id),
      .b_fire(b_fire), .outst_cnt(outst_cnt),
      .err_wlast(err_wlast), .err_b_underflow(err_b_underflow)
   );

   always #5 clk = ~clk;

   typedef struct { int len; int tgt; int id; } burst_t;
   typedef struct { bit head; bit tail; int tgt; int id; } beat_t;

   burst_t bursts[$];
   beat_t  beats[$];
   int beat_idx = 0;
   int outst = 0;
   bit pend_wl = 0;
   bit pend_uf = 0;
   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per cycle, using only the inputs the bench drove.
   task automatic modelStep();
      bit aw_ok, w_ok, aw_hs, w_hs, tail;
      int nb;
      if (rst) begin
         checkOutput("rst_awready", s_awready, 0);
         checkOutput("rst_awvalid", m_aw_valid, 0);
         checkOutput("rst_wready", s_wready, 0);
         checkOutput("rst_wvalid", m_w_valid, 0);
         bursts.delete();
         beats.delete();
         beat_idx = 0;
         outst = 0;
         pend_wl = 0;
         pend_uf = 0;
         return;
      end
      nb = bursts.size();
      aw_ok = (nb < DEPTH) && (outst < MAX_OUTST);
      w_ok  = (nb > 0);
      checkOutput("awready", s_awready, int'(m_aw_ready && aw_ok));
      checkOutput("awvalid", m_aw_valid, int'(s_awvalid && aw_ok));
      checkOutput("wready", s_wready, int'(m_w_ready && w_ok));
      checkOutput("wvalid", m_w_valid, int'(s_wvalid && w_ok));
      checkOutput("outst_cnt", outst_cnt, outst);
      checkOutput("err_wlast", err_wlast, int'(pend_wl));
      checkOutput("err_b_underflow", err_b_underflow, int'(pend_uf));
      if (nb == 0) begin
         checkOutput("empty_head", m_w_head, 1);
         checkOutput("empty_tail", m_w_tail, 1);
         checkOutput("empty_tgt", m_w_tgtid, 0);
         checkOutput("empty_id", m_w_id, 0);
      end
      aw_hs = s_awvalid && m_aw_ready && aw_ok;
      w_hs  = s_wvalid && m_w_ready && w_ok;
      tail  = w_ok && (beat_idx == bursts[0].len);
      pend_wl = w_hs && (s_wlast != tail);
      pend_uf = b_fire && (outst == 0);
      if (aw_hs && !b_fire) outst++;
      else if (!aw_hs && b_fire && outst > 0) outst--;
      if (w_hs) begin
         if (tail) begin
            void'(bursts.pop_front());
            beat_idx = 0;
         end else begin
            beat_idx++;
         end
      end
      if (aw_hs) begin
         burst_t b;
         b.len = int'(s_awlen);
         b.tgt = int'(s_aw_tgtid);
         b.id  = int'(s_awid[9:0]);
         bursts.push_back(b);
         for (int i = 0; i <= b.len; i++) begin
            beat_t e;
            e.head = (i == 0);
            e.tail = (i == b.len);
            e.tgt  = b.tgt;
            e.id   = b.id;
            beats.push_back(e);
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit awv, input int id, input int len,
                                input int tgt, input bit awr, input bit wv, input bit wl,
                                input bit wr, input bit bf);
      @(negedge clk);
      rst        = r;
      s_awvalid  = awv;
      s_awid     = 11'(id);
      s_awlen    = 8'(len);
      s_aw_tgtid = 2'(tgt);
      m_aw_ready = awr;
      s_wvalid   = wv;
      s_wlast    = wl;
      m_w_ready  = wr;
      b_fire     = bf;
      #1;
      modelStep();
   endtask

   // Monitor: every accepted NoC W beat is matched against the next expected beat.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && m_w_valid && m_w_ready) begin
            if (beats.size() == 0) begin
               checkOutput("beat_unexpected", 1, 0);
            end else begin
               beat_t e;
               e = beats.pop_front();
               checkOutput("beat_head", m_w_head, int'(e.head));
               checkOutput("beat_tail", m_w_tail, int'(e.tail));
               checkOutput("beat_tgt", m_w_tgtid, e.tgt);
               checkOutput("beat_id", m_w_id, e.id);
            end
         end
      end
   end

   initial begin
      bit wl;
      $display("[TB] start");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Single write: id 0x155, len 3, tgt 2, then four beats and one B.
      applyStimulus(0, 1, 'h155, 3, 2, 1, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, i == 3, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Queue full: keep AW pending, then release one tail at a time.
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 16 + i, 0, i % 4, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32 + i, 0, 1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);

      // Outstanding limit: AW held while B responses trickle in.
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 48 + i, 0, 3, 1, 1, 1, 1, i == 1);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);

      // WLAST mismatch on beat 1 of a len 1 burst.
      applyStimulus(0, 1, 'h2aa, 1, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Simultaneous AW and B at a count of 3, then underflow at 0.
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 64 + i, 0, 2, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 70, 0, 2, 1, 1, 1, 1, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      applyStimulus(0, 1, 71, 0, 0, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Reset after beat 2 of a len 3 burst, then a fresh write.
      applyStimulus(0, 1, 'h0f0, 3, 3, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, 1, 1);
      applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus(0, 1, 'h3c3, 1, 1, 1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         bit tail;
         tail = (bursts.size() == 0) ? 1'b1 : (beat_idx == bursts[0].len);
         wl = ($urandom_range(7) == 0) ? !tail : tail;
         applyStimulus($urandom_range(299) == 0, $urandom_range(1) == 1, int'($urandom),
                       int'($urandom_range(3)), int'($urandom_range(3)),
                       $urandom_range(3) != 0, $urandom_range(9) < 7, wl,
                       $urandom_range(3) != 0, $urandom_range(9) < 3);
      end

      // Drain every queued burst.
      for (int n = 0; n < 40; n++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("drain_beats_left", beats.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
